// File: rtl/spi_cfg_seq.sv
// spi_cfg_seq: walks a table of configuration words and pushes each one
// through a single-word SPI master. For every word the master is held in
// reset, chip-select drops, the master is enabled until it reports finished,
// then chip-select rises and a fixed gap is observed before the next word.
// Optional feature macro: SPI_CFG_TIMEOUT_EN (bounded XFER wait with error flag).
module spi_cfg_seq #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDR_W     = 4,
  parameter int CS_SETUP   = 8,
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_words,
  output logic [ADDR_W-1:0]    tbl_addr,
  input  logic [DATAWIDTH-1:0] tbl_data,
  output logic [DATAWIDTH-1:0] spi_din,
  output logic                 spi_en,
  output logic                 spi_rst,
  input  logic                 spi_finished,
  output logic                 cs_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_XFER, S_GAP, S_DONE
  } state_t;

  // One shared counter serves SETUP, GAP and (optionally) XFER, so size it
  // for the largest of the three.
  localparam int CNT_A   = (CS_SETUP > GAP_CYCLES) ? CS_SETUP : GAP_CYCLES;
  localparam int CNT_MAX = (CNT_A > TIMEOUT) ? CNT_A : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // SETUP spends its first cycle dropping cs_n/spi_rst, then CS_SETUP more
  // cycles with cs_n low before spi_en rises, hence the terminal count of
  // CS_SETUP rather than CS_SETUP-1.
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0]   MAX_WORDS  = {1'b1, {ADDR_W{1'b0}}};

  state_t           state;
  logic [ADDR_W:0]  idx;
  logic [ADDR_W:0]  nwords;
  logic [ADDR_W:0]  idx_nxt;
  logic [CNT_W-1:0] cnt;

  assign idx_nxt  = idx + 1'b1;
  assign tbl_addr = idx[ADDR_W-1:0];

`ifdef SPI_CFG_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`else
  assign error = 1'b0;
`endif

  // Sequencer FSM; every output is a register updated on the transition
  // into the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      nwords  <= '0;
      cnt     <= '0;
      spi_din <= '0;
      spi_en  <= 1'b0;
      spi_rst <= 1'b1;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SPI_CFG_TIMEOUT_EN
      error   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= '0;
            nwords <= (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
`ifdef SPI_CFG_TIMEOUT_EN
            error  <= 1'b0;
`endif
            if (num_words == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          spi_din <= tbl_data;
          cnt     <= '0;
          state   <= S_SETUP;
        end
        S_SETUP: begin
          cs_n    <= 1'b0;
          spi_rst <= 1'b0;
          if (cnt == SETUP_LAST) begin
            cnt    <= '0;
            spi_en <= 1'b1;
            state  <= S_XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (spi_finished) begin
            spi_en  <= 1'b0;
            cs_n    <= 1'b1;
            spi_rst <= 1'b1;
            cnt     <= '0;
            state   <= S_GAP;
          end
`ifdef SPI_CFG_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            spi_en  <= 1'b0;
            cs_n    <= 1'b1;
            spi_rst <= 1'b1;
            error   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx_nxt == nwords) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx_nxt;
              state <= S_LOAD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_seq.sv
// Testbench for spi_cfg_seq: behavioural SPI master, randomized tables,
// expected-word and expected-done queues consumed by a negedge monitor.
module tb_spi_cfg_seq;
  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int CSS = 8;
  localparam int GAP = 64;
  localparam int TO  = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic [DW-1:0] spi_din;
  logic          spi_en, spi_rst, cs_n, busy, done, error;
  logic          spi_finished = 1'b0;

  logic [DW-1:0] tbl [8];
  assign tbl_data = tbl[tbl_addr];

  spi_cfg_seq #(.DATAWIDTH(DW), .ADDR_W(AW), .CS_SETUP(CSS),
                .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .spi_din(spi_din),
    .spi_en(spi_en), .spi_rst(spi_rst), .spi_finished(spi_finished),
    .cs_n(cs_n), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q [$];
  bit            done_q [$];
  int  win_cnt = 0;
  int  done_cnt = 0;
  int  cur_lat = 5;
  bit  hang = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural SPI master: finishes cur_lat cycles after enable, sticky until reset.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || spi_rst) begin
        spi_finished = 1'b0;
        cnt = 0;
        cur_lat = hang ? TO : int'($urandom_range(5, 30));
      end else if (spi_en) begin
        cnt++;
        if (!hang && cnt >= cur_lat) spi_finished = 1'b1;
      end
    end
  end

  // Monitor: consumes expected words on each enable rise and done events on each done pulse.
  initial begin
    bit p_en, p_cs, p_done, have_prev;
    int pre, gapc, len, lat;
    logic [DW-1:0] din, e;
    p_en = 0; p_cs = 1; p_done = 0; have_prev = 0;
    pre = 0; gapc = 0; len = 0; lat = 0; din = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_en = 0; p_cs = 1; p_done = 0; have_prev = 0; pre = 0; gapc = 0; len = 0;
      end else begin
        if (!cs_n && p_cs) begin
          if (have_prev) begin
            n_checks++;
            if (gapc < GAP + 2) begin
              n_errors++;
              $display("FAIL cs_gap: got %0d cycles required >= %0d", gapc, GAP + 2);
            end
          end
          pre = 0;
        end
        if (cs_n && !p_cs) begin gapc = 0; have_prev = 1; end
        if (cs_n) gapc++;
        if (!cs_n && !spi_en) pre++;
        if (spi_en && !p_en) begin
          chk("cs_setup_cycles", pre, CSS);
          win_cnt++;
          lat = cur_lat;
          len = 0;
          din = spi_din;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_word: got %0h required none", spi_din);
          end else begin
            e = exp_q.pop_front();
            n_checks--;
            chk("word_data", spi_din, e);
          end
        end
        if (spi_en) begin
          len++;
          chk("din_stable", spi_din, din);
          chk("en_cs_rst", {cs_n, spi_rst}, 2'b00);
        end
        if (!spi_en && p_en) chk("en_length", len, lat);
        if (cs_n) chk("rst_when_cs_high", spi_rst, 1);
        if (!cs_n) chk("busy_in_window", busy, 1);
        if (done) begin
          done_cnt++;
          chk("done_single_pulse", p_done, 0);
          chk("busy_in_done", busy, 0);
          chk("words_left_at_done", exp_q.size(), 0);
          n_checks++;
          if (done_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_done: got done=1 required 0");
          end else begin
            bit ee;
            ee = done_q.pop_front();
            n_checks--;
            chk("error_at_done", error, ee);
          end
        end
        p_en = spi_en; p_cs = cs_n; p_done = done;
      end
    end
  end

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    num_words = n[AW:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) tbl[i] = $urandom();
  endtask

  task automatic run(input int n, input bit poke);
    int k, w0, d0, cyc;
    k = (n > 2**AW) ? 2**AW : n;
    if (hang && k > 1) k = 1;
    for (int i = 0; i < k; i++) exp_q.push_back(tbl[i]);
    done_q.push_back(hang);
    w0 = win_cnt; d0 = done_cnt;
    pulse_start(n);
    chk("error_cleared_by_start", error, 0);
    if (n == 0) chk("zero_done_latency", done, 1);
    else        chk("busy_after_start", busy, 1);
    if (poke) begin
      cyc = 0;
      while (cs_n === 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
      chk("reach_setup", cyc < 100, 1);
      num_words = AW'(1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (n == 0) chk("zero_idle_outputs", {busy, cs_n, spi_en}, 3'b010);
    end
    chk("done_within_budget", done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    chk("window_count", win_cnt - w0, k);
    chk("done_count", done_cnt - d0, 1);
    chk("exp_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int w0, cyc;
    for (int i = 0; i < 8; i++) tbl[i] = '0;
    #23;
    chk("rst_outputs", {cs_n, spi_rst, spi_en, busy, done, error}, 6'b110000);
    chk("rst_din", spi_din, 0);
    chk("rst_addr", tbl_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outputs", {cs_n, spi_rst, spi_en, busy, done, error}, 6'b110000);

    // Known three-word table.
    tbl[0] = 32'h12345678; tbl[1] = 32'hA5A5A5A5; tbl[2] = 32'h0000FFFF;
    run(3, 0);
    // Zero words.
    run(0, 0);
    // Repeated start during SETUP of word 0 is ignored.
    tbl[0] = 32'h12345678; tbl[1] = 32'hA5A5A5A5; tbl[2] = 32'h0000FFFF;
    run(3, 1);
    // Random tables and lengths, including a clamped oversize request.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run(int'($urandom_range(1, 8)), 0);
    end
    fill_random();
    run(int'($urandom_range(9, 15)), 0);

    // Asynchronous reset during word 1 transfer.
    fill_random();
    w0 = win_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(tbl[i]);
    pulse_start(4);
    cyc = 0;
    while (win_cnt < w0 + 2 && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("reach_word1", win_cnt, w0 + 2);
    chk("pre_rst_en", spi_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {cs_n, spi_en, spi_rst, busy, done, error}, 6'b101000);
    chk("abort_addr", tbl_addr, 0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fill_random();
    run(3, 0);

`ifdef SPI_CFG_TIMEOUT_EN
    // Master never finishes: one word, TO-cycle enable, error with done.
    fill_random();
    hang = 1'b1;
    run(5, 0);
    hang = 1'b0;
    repeat (5) @(negedge clk);
    chk("error_sticky", error, 1);
    fill_random();
    run(2, 0);
    chk("error_after_good_run", error, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end
endmodule
